// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the 640x480@60 raster generator: default timing,
// derived sync positions and the colour/coordinate widths.
package vga_timing_pkg;

    localparam int C_H_ACTIVE = 640;
    localparam int C_H_FP     = 16;
    localparam int C_H_SYNC   = 96;
    localparam int C_H_BP     = 48;
    localparam int C_V_ACTIVE = 480;
    localparam int C_V_FP     = 10;
    localparam int C_V_SYNC   = 2;
    localparam int C_V_BP     = 33;

    localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
    localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

    localparam int C_H_SYNC_START = C_H_ACTIVE + C_H_FP;
    localparam int C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC - 1;
    localparam int C_V_SYNC_START = C_V_ACTIVE + C_V_FP;
    localparam int C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC - 1;

    localparam int RGB_W = 6;
    localparam int CNT_W = 10;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    // Active-high flags carried through the alignment delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate link between the raster generator (master) and the pixel
// generators (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    // x/y hold for a whole pixel period and pix_ce marks its last clk; the
    // slave answers with pixel_in for those coordinates LATENCY pix_ce later.
    // There is no back-pressure: every pix_ce is a transfer.
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           pix_ce;
    logic           pixel_in;

    modport master (output x, y, pix_ce, input pixel_in);
    modport slave  (input x, y, pix_ce, output pixel_in);

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register with synchronous clear; aligns the raw
// sync/de flags with the pixel generator latency.
module sync_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= CLR_VAL;
            end
        end else if (i_en) begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, coordinate presentation, latency-aligned sync/de/colour
// and the start-of-vertical-blank frame tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = 1,
    parameter int LATENCY  = 1,
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int H_FP     = C_H_FP,
    parameter int H_SYNC   = C_H_SYNC,
    parameter int H_BP     = C_H_BP,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int V_FP     = C_V_FP,
    parameter int V_SYNC   = C_V_SYNC,
    parameter int V_BP     = C_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master pix_if,
    input  logic [RGB_W-1:0] fg_color,
    input  logic [RGB_W-1:0] bg_color,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC - 1;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC - 1;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;

    logic             w_ce;
    logic             w_div_last;
    logic             w_h_last;
    logic             w_v_last;
    sync_bits_t       w_raw;
    sync_bits_t       w_tail;

    // Gating with rst keeps pix_ce low while held in reset even at PIX_DIV=1.
    assign w_div_last = (r_div == DIV_W'(PIX_DIV - 1));
    assign w_ce       = !rst && w_div_last;
    assign w_h_last   = (r_hcnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last   = (r_vcnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_ce) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign pix_if.x      = (r_hcnt < CNT_W'(H_ACTIVE)) ? r_hcnt : '0;
    assign pix_if.y      = (r_vcnt < CNT_W'(V_ACTIVE)) ? r_vcnt[Y_W-1:0] : '0;
    assign pix_if.pix_ce = w_ce;

    assign w_raw.hs = (r_hcnt >= CNT_W'(H_SS)) && (r_hcnt <= CNT_W'(H_SE));
    assign w_raw.vs = (r_vcnt >= CNT_W'(V_SS)) && (r_vcnt <= CNT_W'(V_SE));
    assign w_raw.de = (r_hcnt < CNT_W'(H_ACTIVE)) && (r_vcnt < CNT_W'(V_ACTIVE));

    sync_delay_line #(
        .DEPTH  (LATENCY),
        .WIDTH  ($bits(sync_bits_t)),
        .CLR_VAL('0)
    ) u_sync_dly (
        .clk  (clk),
        .i_en (w_ce),
        .i_clr(rst),
        .i_d  (w_raw),
        .o_q  (w_tail)
    );

    // The tail of the delay line matches the coordinates pixel_in answers for,
    // so sync, de and colour all register on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= !SYNC_POL;
            r_vsync <= !SYNC_POL;
            r_de    <= 1'b0;
            r_rgb   <= '0;
        end else if (w_ce) begin
            r_hsync <= w_tail.hs ? SYNC_POL : !SYNC_POL;
            r_vsync <= w_tail.vs ? SYNC_POL : !SYNC_POL;
            r_de    <= w_tail.de;
            r_rgb   <= w_tail.de ? (pix_if.pixel_in ? fg_color : bg_color) : '0;
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign de         = r_de;
    assign rgb        = r_rgb;
    assign frame_tick = w_ce && w_h_last && (r_vcnt == CNT_W'(V_ACTIVE - 1));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: one full-timing instance (first lines only) and three
// reduced-raster instances (16x12 totals) covering latency, divider and reset.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    vga_timing_gen_if if_f  ();
    vga_timing_gen_if if_l1 ();
    vga_timing_gen_if if_l3 ();
    vga_timing_gen_if if_d2 ();

    logic [5:0] bg_l1 = 6'h00;
    logic       hs_f, vs_f, de_f, ft_f;
    logic       hs_1, vs_1, de_1, ft_1;
    logic       hs_3, vs_3, de_3, ft_3;
    logic       hs_d, vs_d, de_d, ft_d;
    logic [5:0] rgb_f, rgb_1, rgb_3, rgb_d;
    logic [1:0] g3;

    vga_timing_gen u_f (
        .clk(clk), .rst(rst), .pix_if(if_f), .fg_color(6'h3F), .bg_color(6'h00),
        .hsync(hs_f), .vsync(vs_f), .de(de_f), .rgb(rgb_f), .frame_tick(ft_f)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .LATENCY(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_l1 (
        .clk(clk), .rst(rst), .pix_if(if_l1), .fg_color(6'h3F), .bg_color(bg_l1),
        .hsync(hs_1), .vsync(vs_1), .de(de_1), .rgb(rgb_1), .frame_tick(ft_1)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .LATENCY(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_l3 (
        .clk(clk), .rst(rst), .pix_if(if_l3), .fg_color(6'h3F), .bg_color(6'h00),
        .hsync(hs_3), .vsync(vs_3), .de(de_3), .rgb(rgb_3), .frame_tick(ft_3)
    );

    vga_timing_gen #(
        .PIX_DIV(2), .LATENCY(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_d2 (
        .clk(clk), .rst(rst), .pix_if(if_d2), .fg_color(6'h3F), .bg_color(6'h15),
        .hsync(hs_d), .vsync(vs_d), .de(de_d), .rgb(rgb_d), .frame_tick(ft_d)
    );

    // Pixel generator models: a single lit pixel, registered through 1 or 3 stages.
    always @(posedge clk) begin
        if (rst) begin
            if_f.pixel_in  <= 1'b0;
            if_l1.pixel_in <= 1'b0;
            if_l3.pixel_in <= 1'b0;
            g3             <= 2'b00;
        end else begin
            if (if_f.pix_ce)  if_f.pixel_in  <= (if_f.x == 10'd100) && (if_f.y == 9'd1);
            if (if_l1.pix_ce) if_l1.pixel_in <= (if_l1.x == 10'd3) && (if_l1.y == 9'd2);
            if (if_l3.pix_ce) begin
                g3[0]          <= (if_l3.x == 10'd3) && (if_l3.y == 9'd2);
                g3[1]          <= g3[0];
                if_l3.pixel_in <= g3[1];
            end
        end
    end
    assign if_d2.pixel_in = 1'b1;

    int fh_f1, fh_f2, fh_r1, l1h_f1, l1h_f2, l1h_r1, l1v_f1, l1v_f2, l1v_r1;
    int l3h_f1, l3h_f2, l3h_r1, l3v_f1, l3v_f2, l3v_r1, d2h_f1, d2h_f2, d2h_r1;
    logic p_fh, p_l1h, p_l1v, p_l3h, p_l3v, p_d2h;
    int l1_rgb_n, l1_rgb_1st, l3_rgb_n, l3_rgb_1st, f_rgb_n, f_rgb_1st;
    int l1_ft_n, l1_ft_1st, l1_ft_2nd, f_ft_n, f_vs_lo;
    int d2_ft_n, d2_de_n, d2_rgb_n, d2_viol;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic trk(input logic cur, input logic prv, input int k,
                       inout int f1, inout int f2, inout int r1);
        if (prv === 1'b1 && cur === 1'b0) begin
            if (f1 == 0) f1 = k;
            else if (f2 == 0) f2 = k;
        end
        if (prv === 1'b0 && cur === 1'b1 && f1 != 0 && r1 == 0) r1 = k;
    endtask

    task automatic clear_obs();
        fh_f1 = 0; fh_f2 = 0; fh_r1 = 0; l1h_f1 = 0; l1h_f2 = 0; l1h_r1 = 0;
        l1v_f1 = 0; l1v_f2 = 0; l1v_r1 = 0; l3h_f1 = 0; l3h_f2 = 0; l3h_r1 = 0;
        l3v_f1 = 0; l3v_f2 = 0; l3v_r1 = 0; d2h_f1 = 0; d2h_f2 = 0; d2h_r1 = 0;
        p_fh = 1'b1; p_l1h = 1'b1; p_l1v = 1'b1; p_l3h = 1'b1; p_l3v = 1'b1; p_d2h = 1'b1;
        l1_rgb_n = 0; l1_rgb_1st = 0; l3_rgb_n = 0; l3_rgb_1st = 0; f_rgb_n = 0; f_rgb_1st = 0;
        l1_ft_n = 0; l1_ft_1st = 0; l1_ft_2nd = 0; f_ft_n = 0; f_vs_lo = 0;
        d2_ft_n = 0; d2_de_n = 0; d2_rgb_n = 0; d2_viol = 0;
    endtask

    task automatic observe(input int k);
        trk(hs_f, p_fh, k, fh_f1, fh_f2, fh_r1);    p_fh  = hs_f;
        trk(hs_1, p_l1h, k, l1h_f1, l1h_f2, l1h_r1); p_l1h = hs_1;
        trk(vs_1, p_l1v, k, l1v_f1, l1v_f2, l1v_r1); p_l1v = vs_1;
        trk(hs_3, p_l3h, k, l3h_f1, l3h_f2, l3h_r1); p_l3h = hs_3;
        trk(vs_3, p_l3v, k, l3v_f1, l3v_f2, l3v_r1); p_l3v = vs_3;
        trk(hs_d, p_d2h, k, d2h_f1, d2h_f2, d2h_r1); p_d2h = hs_d;
        if (rgb_1 !== 6'h00) begin l1_rgb_n++; if (l1_rgb_1st == 0) l1_rgb_1st = k; end
        if (rgb_3 !== 6'h00) begin l3_rgb_n++; if (l3_rgb_1st == 0) l3_rgb_1st = k; end
        if (rgb_f !== 6'h00) begin f_rgb_n++;  if (f_rgb_1st == 0)  f_rgb_1st = k;  end
        if (ft_1 === 1'b1) begin
            l1_ft_n++;
            if (l1_ft_1st == 0) l1_ft_1st = k;
            else if (l1_ft_2nd == 0) l1_ft_2nd = k;
        end
        if (ft_f === 1'b1) f_ft_n++;
        if (vs_f !== 1'b1) f_vs_lo++;
        if (ft_d === 1'b1) d2_ft_n++;
        if (k <= 384) begin
            if (de_d === 1'b1) d2_de_n++;
            if (rgb_d === 6'h3F) d2_rgb_n++;
        end
        if (de_d === 1'b1 ? (rgb_d !== 6'h3F) : (rgb_d !== 6'h00)) d2_viol++;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_x", if_l1.x, 0);
        chk("rst_y", if_l1.y, 0);
        chk("rst_pix_ce", if_l1.pix_ce, 0);
        chk("rst_d2_pix_ce", if_d2.pix_ce, 0);
        chk("rst_hsync", hs_1, 1);
        chk("rst_vsync", vs_1, 1);
        chk("rst_de", de_1, 0);
        chk("rst_rgb", rgb_1, 0);
        chk("rst_frame_tick", ft_1, 0);
        chk("rst_full_hsync", hs_f, 1);
        chk("rst_l3_de", de_3, 0);

        // Free run from reset release
        rst = 1'b0;
        clear_obs();
        for (int k = 1; k <= 2000; k++) begin
            tick(1);
            observe(k);
            if (k == 1) begin
                chk("full_x_k1", if_f.x, 1);
                chk("l1_x_k1", if_l1.x, 1);
                chk("l1_y_k1", if_l1.y, 0);
                chk("d2_pce_k1", if_d2.pix_ce, 1);
                chk("d2_x_k1", if_d2.x, 0);
            end
            if (k == 2) begin
                chk("d2_pce_k2", if_d2.pix_ce, 0);
                chk("d2_x_k2", if_d2.x, 1);
            end
            if (k == 3)   chk("d2_x_k3", if_d2.x, 1);
            if (k == 4)   chk("d2_x_k4", if_d2.x, 2);
            if (k == 50)  begin chk("l1_x_k50", if_l1.x, 2); chk("l1_y_k50", if_l1.y, 3); end
            if (k == 100) begin chk("l1_x_vblank", if_l1.x, 4); chk("l1_y_vblank", if_l1.y, 0); end
            if (k == 193) begin chk("l1_x_wrap", if_l1.x, 1); chk("l1_y_wrap", if_l1.y, 0); end
            if (k == 190) chk("d2_ft_k190", ft_d, 0);
            if (k == 191) chk("d2_ft_k191", ft_d, 1);
            if (k == 192) chk("d2_ft_k192", ft_d, 0);
            if (k == 639) chk("full_x_639", if_f.x, 639);
            if (k == 640) chk("full_x_hblank", if_f.x, 0);
            if (k == 800) begin chk("full_x_k800", if_f.x, 0); chk("full_y_k800", if_f.y, 1); end
            if (k == 1000) begin chk("full_x_k1000", if_f.x, 200); chk("full_y_k1000", if_f.y, 1); end
        end
        chk("full_hs_fall", fh_f1, 658);
        chk("full_hs_rise", fh_r1, 754);
        chk("full_hs_fall2", fh_f2, 1458);
        chk("full_rgb_first", f_rgb_1st, 902);
        chk("full_rgb_count", f_rgb_n, 1);
        chk("full_vs_low", f_vs_lo, 0);
        chk("full_ft_count", f_ft_n, 0);
        chk("l1_hs_fall", l1h_f1, 12);
        chk("l1_hs_rise", l1h_r1, 15);
        chk("l1_hs_fall2", l1h_f2, 28);
        chk("l1_vs_fall", l1v_f1, 130);
        chk("l1_vs_rise", l1v_r1, 162);
        chk("l1_vs_fall2", l1v_f2, 322);
        chk("l1_rgb_first", l1_rgb_1st, 37);
        chk("l1_rgb_count", l1_rgb_n, 11);
        chk("l1_ft_first", l1_ft_1st, 95);
        chk("l1_ft_second", l1_ft_2nd, 287);
        chk("l1_ft_count", l1_ft_n, 10);
        chk("l3_hs_fall", l3h_f1, 14);
        chk("l3_vs_fall", l3v_f1, 132);
        chk("l3_rgb_first", l3_rgb_1st, 39);
        chk("l3_rgb_count", l3_rgb_n, 11);
        chk("d2_hs_fall", d2h_f1, 24);
        chk("d2_hs_rise", d2h_r1, 30);
        chk("d2_hs_fall2", d2h_f2, 56);
        chk("d2_ft_count", d2_ft_n, 5);
        chk("d2_de_count", d2_de_n, 96);
        chk("d2_rgb_count", d2_rgb_n, 96);
        chk("d2_mask_viol", d2_viol, 0);

        // Colour change mid-frame
        bg_l1 = 6'h0A;
        tick(1);
        chk("l1_rgb_hblank", rgb_1, 6'h00);
        tick(3);
        chk("l1_de_active", de_1, 1);
        chk("l1_bg_first", rgb_1, 6'h0A);
        bg_l1 = 6'h2A;
        tick(1);
        chk("l1_bg_second", rgb_1, 6'h2A);
        chk("full_x_pre_rst", if_f.x, 405);
        chk("full_y_pre_rst", if_f.y, 2);
        chk("full_de_pre_rst", de_f, 1);
        chk("l1_x_pre_rst", if_l1.x, 5);
        chk("l1_y_pre_rst", if_l1.y, 5);

        // Reset mid-line
        rst   = 1'b1;
        bg_l1 = 6'h00;
        tick(1);
        chk("mrst_x", if_l1.x, 0);
        chk("mrst_y", if_l1.y, 0);
        chk("mrst_de", de_1, 0);
        chk("mrst_hsync", hs_1, 1);
        chk("mrst_vsync", vs_1, 1);
        chk("mrst_rgb", rgb_1, 0);
        chk("mrst_ft", ft_1, 0);
        chk("mrst_full_x", if_f.x, 0);
        chk("mrst_full_y", if_f.y, 0);
        chk("mrst_full_de", de_f, 0);
        chk("mrst_d2_pce", if_d2.pix_ce, 0);
        rst = 1'b0;
        clear_obs();
        for (int k = 1; k <= 300; k++) begin
            tick(1);
            observe(k);
            if (k == 1) begin
                chk("rr_l1_x", if_l1.x, 1);
                chk("rr_l1_y", if_l1.y, 0);
                chk("rr_full_x", if_f.x, 1);
            end
            if (k == 4) chk("rr_d2_x", if_d2.x, 2);
        end
        chk("rr_l1_hs_fall", l1h_f1, 12);
        chk("rr_l1_vs_fall", l1v_f1, 130);
        chk("rr_l1_rgb_first", l1_rgb_1st, 37);
        chk("rr_l1_rgb_count", l1_rgb_n, 2);
        chk("rr_l1_ft_first", l1_ft_1st, 95);
        chk("rr_l1_ft_count", l1_ft_n, 2);
        chk("rr_l3_rgb_first", l3_rgb_1st, 39);
        chk("rr_d2_hs_fall", d2h_f1, 24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
